// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin arbiter/sequencer sharing one Fibonacci FSMD
// unit among N_REQ requesters; issues start, waits, returns result.
// Ports: clk, reset (async, active-high); req/req_i from clients;
// grant/resp_valid/resp_f/resp_err/busy to clients; fib_start/fib_i to
// the unit, fib_ready/fib_done_tick/fib_f from it.
// Optional macro FIB_ARB_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYCLES).
module fib_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [5*N_REQ-1:0]   req_i,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [19:0]          resp_f,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 fib_start,
  output logic [4:0]           fib_i,
  input  logic                 fib_ready,
  input  logic                 fib_done_tick,
  input  logic [19:0]          fib_f
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [4:0]       fib_i_q, fib_i_d;
  logic [19:0]      resp_f_q, resp_f_d;

  logic [4:0]       req_i_a [N_REQ];
  logic             sel_found;
  logic [IDW-1:0]   sel_id;
  logic [4:0]       sel_i;
  logic [IDW:0]     sum;
  logic [IDW-1:0]   idx;
  logic             tmo_hit;
  logic             err_set;
  logic             err_clr;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_i_a[k] = req_i[5*k +: 5];
    end
  end

  // Scan from ptr upward, wrapping, and take the first requester.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_i     = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      idx = sum[IDW-1:0];
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
        sel_i     = req_i_a[idx];
      end
    end
  end

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          resp_err_q, resp_err_d;

  // Counter is held at zero outside WAIT, so it starts clean on entry.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_WAIT) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign tmo_hit = (state_q == S_WAIT) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    resp_err_d = resp_err_q;
    if (err_clr) begin
      resp_err_d = 1'b0;
    end else if (err_set) begin
      resp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;
`else
  assign tmo_hit  = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    fib_i_d  = fib_i_q;
    resp_f_d = resp_f_q;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found && fib_ready) begin
          gnt_id_d = sel_id;
          fib_i_d  = sel_i;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse beats a simultaneous watchdog expiry.
        if (fib_done_tick) begin
          resp_f_d = fib_f;
          err_clr  = 1'b1;
          state_d  = S_RESP;
        end else if (tmo_hit) begin
          resp_f_d = '0;
          err_set  = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (gnt_id_q == IDW'(N_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = gnt_id_q + IDW'(1);
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      fib_i_q  <= '0;
      resp_f_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      fib_i_q  <= fib_i_d;
      resp_f_q <= resp_f_d;
    end
  end

  // Outputs decode only registered state; req never reaches them directly.
  always_comb begin
    grant      = '0;
    resp_valid = '0;
    if (state_q != S_IDLE) begin
      grant[gnt_id_q] = 1'b1;
    end
    if (state_q == S_RESP) begin
      resp_valid[gnt_id_q] = 1'b1;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign fib_start = (state_q == S_ISSUE);
  assign fib_i     = fib_i_q;
  assign resp_f    = resp_f_q;

endmodule
